// File: rtl/serialize_word_to_bit_stream.sv
// Parallel-to-serial stage: accepts WIDTH-bit words over valid/ready and emits them MSB first,
// one bit per clock, with back-to-back words streaming gap-free and a wrapping word counter.
module serialize_word_to_bit_stream #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0,
  parameter int   CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             at_last;
  logic             accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
    end
  end

  always_comb begin
    at_last    = (state_q == SHIFT) && (cnt_q == LAST_IDX);
    in_ready   = ~rst & ((state_q == IDLE) | at_last);
    accept     = in_valid & in_ready;
    out_valid  = (state_q == SHIFT);
    busy       = out_valid;
    out_last   = at_last;
    out_bit    = out_valid ? shreg_q[WIDTH-1] : IDLE_BIT;
    words_sent = words_q;

    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    words_d = words_q;

    // A word completes on its last bit even when a new word is accepted in the same cycle.
    if (at_last) begin
      words_d = words_q + CNT_W'(1);
    end

    if (accept) begin
      shreg_d = in_data;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      if (at_last) begin
        state_d = IDLE;
      end else begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        cnt_d   = cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serialize_word_to_bit_stream.sv
// Scoreboard bench: accepted words are expanded into an expected bit queue; a negedge monitor
// pops and compares every output, plus word counters for a 16-bit and a 2-bit instance.
module tb_serialize_word_to_bit_stream;

  localparam int   WIDTH    = 8;
  localparam logic IDLE_BIT = 1'b0;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready, out_bit, out_valid, out_last, busy;
  logic [15:0]      words_sent;
  logic             in_ready2, out_bit2, out_valid2, out_last2, busy2;
  logic [1:0]       words_sent2;

  typedef struct {
    bit b;
    bit l;
  } exp_bit_t;

  exp_bit_t exp_q[$];
  int  exp_words = 0;
  bit  cur_last  = 0;
  bit  armed     = 0;
  bit  last_acc  = 0;
  int  checks    = 0;
  int  errors    = 0;

  always #5 clk = ~clk;

  serialize_word_to_bit_stream #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_bit(out_bit), .out_valid(out_valid), .out_last(out_last), .busy(busy),
    .words_sent(words_sent)
  );

  serialize_word_to_bit_stream #(.WIDTH(WIDTH), .IDLE_BIT(IDLE_BIT), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready2),
    .out_bit(out_bit2), .out_valid(out_valid2), .out_last(out_last2), .busy(busy2),
    .words_sent(words_sent2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference side: words expand into their bits MSB first; only the final bit is marked last.
  always @(posedge clk) begin
    last_acc = 0;
    if (rst) begin
      exp_q.delete();
      exp_words = 0;
      armed     = 1;
    end else if (armed) begin
      if (cur_last) exp_words++;
      if (in_valid && in_ready) begin
        last_acc = 1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          exp_q.push_back('{b: in_data[i], l: (i == 0)});
        end
        $display("accept word %02h at %0t", in_data, $time);
      end
    end
    cur_last = 0;
  end

  always @(negedge clk) begin
    if (armed) begin
      int       pending;
      exp_bit_t e;
      pending = exp_q.size();
      chk("in_ready", 32'(in_ready), 32'(!rst && pending <= 1));
      chk("in_ready_w2", 32'(in_ready2), 32'(!rst && pending <= 1));
      chk("out_valid", 32'(out_valid), 32'(pending > 0));
      chk("busy", 32'(busy), 32'(pending > 0));
      chk("words_sent", 32'(words_sent), 32'(exp_words % 65536));
      chk("words_sent_w2", 32'(words_sent2), 32'(exp_words % 4));
      if (pending > 0) begin
        e = exp_q.pop_front();
        chk("out_bit", 32'(out_bit), 32'(e.b));
        chk("out_last", 32'(out_last), 32'(e.l));
        cur_last = e.l;
      end else begin
        chk("out_bit_idle", 32'(out_bit), 32'(IDLE_BIT));
        chk("out_last_idle", 32'(out_last), 32'h0);
      end
    end
  end

  // Present a word and hold it until accepted; optionally keep valid high for a follow-on word.
  task automatic send(input logic [WIDTH-1:0] d, input bit hold);
    int n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) chk("accept_timeout", 32'(n), 32'(0));
    in_data = WIDTH'($urandom);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_data = WIDTH'($urandom);
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(10);

    send(8'hB4, 0);
    idle(10);

    send(8'hCC, 1);
    send(8'h33, 0);
    idle(10);

    send(8'h5A, 0);
    idle(2);
    send(8'hFF, 0);
    idle(10);

    send(8'hA5, 0);
    idle(3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    send(8'h01, 0);
    idle(10);

    for (int k = 0; k < 5; k++) send(WIDTH'($urandom), 1);
    in_valid = 1'b0;
    idle(10);

    for (int k = 0; k < 60; k++) begin
      send(WIDTH'($urandom), $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 12));
    end
    in_valid = 1'b0;
    idle(12);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
